// File: rtl/pixel_bit_source.sv
// Pixel bit source for the LED-matrix serializer: sprite bit, colour bit and
// need-level bar colour selected by pixel/bit index, all outputs registered.
module pixel_bit_source #(
    parameter int unsigned NPIX    = 128,
    parameter int unsigned CBITS   = 24,
    parameter int unsigned LOW_LVL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPIX/2-1:0]         data,
    input  logic [$clog2(NPIX)-1:0]   pixel_idx,
    input  logic [CBITS-1:0]          color,
    input  logic [4:0]                bit_idx,
    input  logic [2:0]                humedad,
    input  logic [2:0]                nutricion,
    input  logic [2:0]                energia,
    input  logic [2:0]                mantenimiento,
    input  logic [2:0]                cortado,
    output logic                      pixel_active,
    output logic                      color_bit,
    output logic [CBITS-1:0]          need_color,
    output logic                      need_bit,
    output logic                      dataout
);

    localparam int unsigned HALF    = NPIX / 2;
    localparam int unsigned PIX_W   = $clog2(NPIX);
    localparam int unsigned POS_W   = $clog2(HALF);
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned BIDX_W  = 5;

    localparam logic [LVL_W-1:0]  LOW_LVL_W = LVL_W'(LOW_LVL);
    localparam logic [BIDX_W-1:0] CBITS_W   = BIDX_W'(CBITS);
    localparam logic [BIDX_W-1:0] CMSB_W    = BIDX_W'(CBITS - 1);

    localparam logic [CBITS-1:0] COL_BLACK = CBITS'(24'h000000);
    localparam logic [CBITS-1:0] COL_WARN  = CBITS'(24'hFF0000);
    localparam logic [CBITS-1:0] COL_HUM   = CBITS'(24'h0000FF);
    localparam logic [CBITS-1:0] COL_NUT   = CBITS'(24'h00FF00);
    localparam logic [CBITS-1:0] COL_ENE   = CBITS'(24'hFFFF00);
    localparam logic [CBITS-1:0] COL_MAN   = CBITS'(24'hFF00FF);
    localparam logic [CBITS-1:0] COL_COR   = CBITS'(24'h00FFFF);

    // MSB-first bit pick of a colour word; indices past the word read as 0
    function automatic logic pick_bit(input logic [CBITS-1:0] word,
                                      input logic [BIDX_W-1:0] idx);
        logic b;
        b = 1'b0;
        if (idx < CBITS_W) begin
            b = word[CMSB_W - idx];
        end
        return b;
    endfunction

    logic                   sprite_half;
    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       sprite_bit_pos;
    logic [2:0]             bar_row;
    logic [2:0]             bar_col;
    logic [LVL_W-1:0]       row_level;
    logic [CBITS-1:0]       row_hue;
    logic                   row_valid;

    logic                   pixel_active_d, pixel_active_q;
    logic                   color_bit_d,    color_bit_q;
    logic [CBITS-1:0]       need_color_d,   need_color_q;
    logic                   need_bit_d,     need_bit_q;
    logic                   dataout_d,      dataout_q;

    assign sprite_half    = (pixel_idx[PIX_W-1] == 1'b0);
    assign pos            = pixel_idx[POS_W-1:0];
    assign sprite_bit_pos = POS_W'(HALF - 1) - pos;
    assign bar_row        = pos[5:3];
    assign bar_col        = pos[2:0];

    // Row to need level and its normal hue; rows past the fifth stay black
    always_comb begin
        row_level = '0;
        row_hue   = COL_BLACK;
        row_valid = 1'b0;
        case (bar_row)
            3'd0: begin row_level = humedad;       row_hue = COL_HUM; row_valid = 1'b1; end
            3'd1: begin row_level = nutricion;     row_hue = COL_NUT; row_valid = 1'b1; end
            3'd2: begin row_level = energia;       row_hue = COL_ENE; row_valid = 1'b1; end
            3'd3: begin row_level = mantenimiento; row_hue = COL_MAN; row_valid = 1'b1; end
            3'd4: begin row_level = cortado;       row_hue = COL_COR; row_valid = 1'b1; end
            default: begin
                row_level = '0;
                row_hue   = COL_BLACK;
                row_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        pixel_active_d = 1'b0;
        need_color_d   = COL_BLACK;

        if (sprite_half) begin
            pixel_active_d = data[sprite_bit_pos];
        end else if (row_valid && (bar_col < row_level)) begin
            need_color_d = (row_level <= LOW_LVL_W) ? COL_WARN : row_hue;
        end

        color_bit_d = pick_bit(color, bit_idx);
        need_bit_d  = pick_bit(need_color_d, bit_idx);
        dataout_d   = sprite_half ? color_bit_d : need_bit_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_active_q <= 1'b0;
            color_bit_q    <= 1'b0;
            need_color_q   <= '0;
            need_bit_q     <= 1'b0;
            dataout_q      <= 1'b0;
        end else begin
            pixel_active_q <= pixel_active_d;
            color_bit_q    <= color_bit_d;
            need_color_q   <= need_color_d;
            need_bit_q     <= need_bit_d;
            dataout_q      <= dataout_d;
        end
    end

    assign pixel_active = pixel_active_q;
    assign color_bit    = color_bit_q;
    assign need_color   = need_color_q;
    assign need_bit     = need_bit_q;
    assign dataout      = dataout_q;

endmodule

// File: tb/tb_pixel_bit_source.sv
// Bench for pixel_bit_source: directed cases plus random traffic against an
// arithmetic reference model of the panel layout.
module tb_pixel_bit_source;

    logic        clk;
    logic        rst;
    logic [63:0] data;
    logic [6:0]  pixel_idx;
    logic [23:0] color;
    logic [4:0]  bit_idx;
    logic [2:0]  humedad, nutricion, energia, mantenimiento, cortado;
    logic        pixel_active, color_bit, need_bit, dataout;
    logic [23:0] need_color;

    int checks = 0;
    int errors = 0;

    pixel_bit_source dut (
        .clk           (clk),
        .rst           (rst),
        .data          (data),
        .pixel_idx     (pixel_idx),
        .color         (color),
        .bit_idx       (bit_idx),
        .humedad       (humedad),
        .nutricion     (nutricion),
        .energia       (energia),
        .mantenimiento (mantenimiento),
        .cortado       (cortado),
        .pixel_active  (pixel_active),
        .color_bit     (color_bit),
        .need_color    (need_color),
        .need_bit      (need_bit),
        .dataout       (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (pix=%0d bit=%0d t=%0t)",
                     tag, got, exp, pixel_idx, bit_idx, $time);
        end
    endtask

    // Reference: panel layout computed with plain integer arithmetic
    function automatic void model(output logic pa, output logic cb,
                                  output logic [23:0] nc, output logic nb,
                                  output logic dout);
        int pix, b, p, r, c;
        int lv[5];
        logic [23:0] hues[5];
        lv   = '{int'(humedad), int'(nutricion), int'(energia),
                 int'(mantenimiento), int'(cortado)};
        hues = '{24'h0000FF, 24'h00FF00, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF};
        pix = int'(pixel_idx);
        b   = int'(bit_idx);
        pa = 1'b0; cb = 1'b0; nc = 24'h0; nb = 1'b0; dout = 1'b0;
        if (rst) return;
        if (pix < 64) pa = data[6'(63 - pix)];
        if (b < 24)   cb = color[5'(23 - b)];
        if (pix >= 64) begin
            p = pix - 64;
            r = p / 8;
            c = p % 8;
            if (r < 5 && c < lv[r]) nc = (lv[r] <= 1) ? 24'hFF0000 : hues[r];
        end
        if (b < 24) nb = nc[5'(23 - b)];
        dout = (pix <= 63) ? cb : nb;
    endfunction

    // Clock the current inputs in and compare every output one edge later
    task automatic tick_and_check(input string tag);
        logic        e_pa, e_cb, e_nb, e_do;
        logic [23:0] e_nc;
        model(e_pa, e_cb, e_nc, e_nb, e_do);
        @(posedge clk);
        #1;
        check({tag, ".pixel_active"}, 32'(pixel_active), 32'(e_pa));
        check({tag, ".color_bit"},    32'(color_bit),    32'(e_cb));
        check({tag, ".need_color"},   32'(need_color),   32'(e_nc));
        check({tag, ".need_bit"},     32'(need_bit),     32'(e_nb));
        check({tag, ".dataout"},      32'(dataout),      32'(e_do));
    endtask

    task automatic set_levels(input logic [2:0] h, input logic [2:0] n, input logic [2:0] e,
                              input logic [2:0] m, input logic [2:0] c);
        humedad = h; nutricion = n; energia = e; mantenimiento = m; cortado = c;
    endtask

    initial begin
        logic [23:0] pattern;
        rst = 1'b1;
        data = '1;
        color = 24'hFFFFFF;
        pixel_idx = 7'd0;
        bit_idx = 5'd0;
        set_levels(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        #1;

        // Reset forces zeros even with all-ones inputs
        tick_and_check("reset");
        check("reset.abs_dataout", 32'(dataout), 32'd0);
        rst = 1'b0;
        tick_and_check("release");
        check("release.abs_pixel_active", 32'(pixel_active), 32'd1);
        check("release.abs_dataout", 32'(dataout), 32'd1);

        // Sprite select end points and half boundary
        data = 64'h8000_0000_0000_0001;
        pixel_idx = 7'd0;  tick_and_check("sprite0");
        check("sprite0.abs", 32'(pixel_active), 32'd1);
        pixel_idx = 7'd63; tick_and_check("sprite63");
        check("sprite63.abs", 32'(pixel_active), 32'd1);
        pixel_idx = 7'd1;  tick_and_check("sprite1");
        check("sprite1.abs", 32'(pixel_active), 32'd0);
        pixel_idx = 7'd64; tick_and_check("sprite64");
        check("sprite64.abs", 32'(pixel_active), 32'd0);

        // Colour bit sweep, MSB first, then out-of-range indices
        color = 24'h7BDF68;
        pattern = 24'b0111_1011_1101_1111_0110_1000;
        pixel_idx = 7'd5;
        for (int b = 0; b < 32; b++) begin
            bit_idx = 5'(b);
            tick_and_check("cbit");
            check("cbit.abs", 32'(color_bit), (b < 24) ? 32'(pattern[5'(23 - b)]) : 32'd0);
        end

        // Bars: humedad=3 lights columns 0..2 in its hue
        bit_idx = 5'd0;
        set_levels(3'd3, 3'd0, 3'd0, 3'd0, 3'd0);
        for (int p = 64; p <= 67; p++) begin
            pixel_idx = 7'(p);
            tick_and_check("bar_hum");
            check("bar_hum.abs", 32'(need_color), (p < 67) ? 32'h0000FF : 32'h0);
        end
        energia = 3'd1;
        pixel_idx = 7'd80; tick_and_check("bar_warn");
        check("bar_warn.abs", 32'(need_color), 32'hFF0000);
        set_levels(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
        pixel_idx = 7'd104; tick_and_check("bar_row5");
        check("bar_row5.abs", 32'(need_color), 32'h0);

        // Full and empty levels across the whole bar half
        for (int p = 64; p < 128; p++) begin
            pixel_idx = 7'(p);
            bit_idx = 5'(p % 24);
            tick_and_check("full");
        end
        pixel_idx = 7'd71; tick_and_check("full_col7");
        check("full_col7.abs", 32'(need_color), 32'h0);
        set_levels(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        for (int p = 64; p < 128; p++) begin
            pixel_idx = 7'(p);
            tick_and_check("empty");
        end

        // Output mux follows the same sampled pixel index
        color = 24'hFFFFFF;
        bit_idx = 5'd0;
        data = 64'h0000_0000_0000_0001;
        pixel_idx = 7'd63; tick_and_check("mux63");
        check("mux63.abs", 32'(dataout), 32'd1);
        pixel_idx = 7'd64; tick_and_check("mux64");
        check("mux64.abs", 32'(dataout), 32'd0);
        humedad = 3'd5; bit_idx = 5'd22; tick_and_check("mux64_need");
        check("mux64_need.abs", 32'(dataout), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 31) == 0);
            data      = {$urandom, $urandom};
            color     = 24'($urandom);
            pixel_idx = 7'($urandom);
            bit_idx   = 5'($urandom);
            set_levels(3'($urandom), 3'($urandom), 3'($urandom),
                       3'($urandom), 3'($urandom));
            tick_and_check("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_bit_source.md
Name: pixel_bit_source

Overview:
- Combinational-select datapath feeding the LED-matrix serializer, with registered outputs.
- Merges three functions:
  - 24-bit colour-bit selector (mux24 role).
  - 64-bit sprite-pixel selector (mux64 role).
  - Need-level bar generator (needcomparator role).
- Addressed by pixel index 0..127 of an 8x16 panel:
  - Pixels 0..63 come from the sprite frame.
  - Pixels 64..127 show five 3-bit plant-need levels as horizontal bars.

Parameters:
- NPIX, 128, pixels per frame (sprite half = NPIX/2 = 64).
- CBITS, 24, bits per pixel colour word.
- LOW_LVL, 1, level at or below which a bar is drawn in warning colour.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- data  input  64  sprite frame bitmap, one bit per pixel
- pixel_idx  input  7  current pixel 0..127
- color  input  24  sprite colour word for current pixel
- bit_idx  input  5  current colour bit 0..23, MSB-first
- humedad  input  3  need level 0..7
- nutricion  input  3  need level 0..7
- energia  input  3  need level 0..7
- mantenimiento  input  3  need level 0..7
- cortado  input  3  need level 0..7
- pixel_active  output  1  sprite bit of pixel_idx
- color_bit  output  1  selected bit of color
- need_color  output  24  bar colour for pixel_idx
- need_bit  output  1  selected bit of need_color
- dataout  output  1  serial bit to send

Behaviour:
- All outputs registered. Each output reflects inputs sampled at the previous rising edge (latency 1 cycle).
- Reset: rst=1 at a clock edge forces every output to 0 on that edge. rst has priority over input changes. Deasserting rst resumes normal tracking the next edge.
- pixel_active = data[63 - pixel_idx[5:0]], so pixel 0 maps to data MSB.
  - When pixel_idx >= 64, pixel_active = 0.
- color_bit = color[23 - bit_idx] for bit_idx 0..23.
  - bit_idx 24..31 gives 0.
- Bar geometry for pixel_idx in 64..127:
  - p = pixel_idx - 64, row r = p[5:3], column c = p[2:0].
  - Row 0 shows humedad, row 1 nutricion, row 2 energia, row 3 mantenimiento, row 4 cortado.
  - Rows 5..7 are always black (0x000000).
- Pixel lit iff c < level.
  - Level 0 gives an empty row; level 7 lights columns 0..6; column 7 is never lit.
- Lit colour:
  - level <= LOW_LVL: warning 0xFF0000.
  - otherwise per need: humedad 0x0000FF, nutricion 0x00FF00, energia 0xFFFF00, mantenimiento 0xFF00FF, cortado 0x00FFFF.
  - Unlit pixels are 0x000000.
- pixel_idx < 64 gives need_color = 0x000000.
- need_bit = need_color[23 - bit_idx]. Bits beyond 23 give 0. Uses the combinational need_color of the same sampled inputs, not the registered one.
- dataout = color_bit source when pixel_idx <= 63, else need_bit source. The choice uses the same sampled pixel_idx, so dataout is consistent with the other outputs on the same edge.
- Widths: all index comparisons unsigned. No arithmetic overflow possible (p fits in 6 bits).
- No internal state besides output registers. Input changes mid-pixel simply take effect next edge.

Test Plan:
- Reset: drive data=all ones, color=0xFFFFFF, rst=1 one edge -> all outputs 0. Release rst with pixel_idx=0, bit_idx=0 -> next edge pixel_active=1, color_bit=1, dataout=1.
- Sprite select: data=0x8000_0000_0000_0001. pixel_idx=0 -> pixel_active=1; pixel_idx=63 -> 1; pixel_idx=1 -> 0; pixel_idx=64 -> 0.
- Colour bit: color=0x7BDF68, sweep bit_idx 0..23 -> color_bit sequence 0111_1011_1101_1111_0110_1000. bit_idx=24 -> 0.
- Bars: humedad=3 (others 0):
  - pixel_idx 64..66 -> need_color 0x0000FF.
  - pixel_idx 67 -> 0.
  - energia=1 at pixel_idx 80 -> 0xFF0000 (warning).
  - pixel_idx 104 (row 5) -> 0 regardless of levels.
- Boundary: all levels=7 -> row columns 0..6 lit, column 7 (pixel_idx 71, 79, ...) black. All levels 0 -> every bar pixel 0.
- dataout mux: color=0xFFFFFF, humedad=0, bit_idx=0. pixel_idx=63 with data bit set -> dataout=1. pixel_idx=64 -> dataout=0. Set humedad=5, pixel_idx=64, bit_idx=22 -> dataout=1 (0x0000FF bit 1).
